// File: rtl/chacha_seq_pkg.sv
// Shared types and widths for the ChaCha20 multi-block keystream sequencer.
package chacha_seq_pkg;

    localparam int WORDS_PER_BLK = 16;
    localparam int BLK_W         = 512;
    localparam int KEY_W         = 256;
    localparam int NONCE_W       = 96;
    localparam int CTR_W         = 32;

    typedef enum logic [1:0] {IDLE, CHECK, RUN, FIN} seq_state_t;

endpackage

// File: rtl/ks_pingpong_buf.sv
// Two-slot keystream block buffer; fills from the block core, drains as 32-bit words.
module ks_pingpong_buf
    import chacha_seq_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             wr_en,
    input  logic [BLK_W-1:0] wr_data,
    input  logic             rd_ready,
    output logic             rd_valid,
    output logic [31:0]      rd_word,
    output logic             rd_last_word,
    output logic             blk_drained,
    output logic             wr_free
);

    logic [BLK_W-1:0] slot0;
    logic [BLK_W-1:0] slot1;
    logic [BLK_W-1:0] rd_blk;
    logic [1:0]       vld;
    logic [1:0]       vld_nx;
    logic             wr_ptr;
    logic             rd_ptr;
    logic [3:0]       widx;
    logic             hs;

    assign rd_valid     = vld[rd_ptr];
    assign hs           = rd_valid & rd_ready;
    assign rd_last_word = (widx == 4'(WORDS_PER_BLK - 1));
    assign blk_drained  = hs & rd_last_word;
    // A slot emptying on this edge may be re-requested now; its data lands much later.
    assign wr_free      = !vld[wr_ptr] || (blk_drained && (rd_ptr == wr_ptr));

    assign rd_blk  = rd_ptr ? slot1 : slot0;
    assign rd_word = rd_valid ? rd_blk[{widx, 5'd0} +: 32] : 32'd0;

    always_comb begin
        vld_nx = vld;
        if (blk_drained)
            vld_nx[rd_ptr] = 1'b0;
        if (wr_en)
            vld_nx[wr_ptr] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            vld    <= 2'b00;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            widx   <= 4'd0;
        end else begin
            vld <= vld_nx;
            if (hs)
                widx <= widx + 4'd1;
            if (blk_drained)
                rd_ptr <= ~rd_ptr;
            if (wr_en)
                wr_ptr <= ~wr_ptr;
        end
    end

    // Block storage carries no reset; visibility is governed by the valid bits.
    always_ff @(posedge clk) begin
        if (wr_en && !wr_ptr)
            slot0 <= wr_data;
        if (wr_en && wr_ptr)
            slot1 <= wr_data;
    end

endmodule

// File: rtl/chacha_keystream_sequencer.sv
// Requests consecutive ChaCha20 blocks from the block core and streams them as 32-bit words.
module chacha_keystream_sequencer
    import chacha_seq_pkg::*;
#(
    parameter int NBLK_W = 32,
    parameter int WORD_W = 32
)
(
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [KEY_W-1:0]   key,
    input  logic [NONCE_W-1:0] nonce,
    input  logic [CTR_W-1:0]   ctr_init,
    input  logic [NBLK_W-1:0]  num_blocks,
    output logic               busy,
    output logic               done,
    output logic               ctr_err,
    output logic               core_start,
    output logic [KEY_W-1:0]   core_key,
    output logic [NONCE_W-1:0] core_nonce,
    output logic [CTR_W-1:0]   core_ctr,
    input  logic               core_done,
    input  logic [BLK_W-1:0]   core_ks,
    output logic               ks_valid,
    input  logic               ks_ready,
    output logic [WORD_W-1:0]  ks_word,
    output logic               ks_last
);

    localparam int SUM_W = ((NBLK_W > CTR_W) ? NBLK_W : CTR_W) + 1;

    seq_state_t        state;
    logic [NBLK_W-1:0] num_q;
    logic [NBLK_W-1:0] issued;
    logic [NBLK_W-1:0] drained;
    logic              outstanding;
    logic              start_acc;
    logic              core_fill;
    logic              last_blk;
    logic              wrap;
    logic [SUM_W-1:0]  ctr_end;
    logic              buf_wr_free;
    logic              buf_last_word;
    logic              blk_drained;

    assign start_acc = (state == IDLE) && start;

    // Last counter of the message, computed one bit wider so a wrap is visible.
    assign ctr_end = SUM_W'(core_ctr) + SUM_W'(num_q) - SUM_W'(1);
    assign wrap    = ctr_end > SUM_W'({CTR_W{1'b1}});

    assign busy    = (state != IDLE);
    assign done    = (state == FIN);
    assign ctr_err = (state == CHECK) && (num_q != '0) && wrap;

    assign core_start = (state == RUN) && (issued < num_q) && !outstanding && buf_wr_free;
    // A core_done without an outstanding request is stale and must not touch the buffer.
    assign core_fill  = core_done && outstanding;

    assign last_blk = (drained == num_q - NBLK_W'(1));
    assign ks_last  = ks_valid && buf_last_word && last_blk;

    ks_pingpong_buf u_buf (
        .clk          (clk),
        .rst          (rst),
        .clr          (start_acc),
        .wr_en        (core_fill),
        .wr_data      (core_ks),
        .rd_ready     (ks_ready),
        .rd_valid     (ks_valid),
        .rd_word      (ks_word),
        .rd_last_word (buf_last_word),
        .blk_drained  (blk_drained),
        .wr_free      (buf_wr_free)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            core_key    <= '0;
            core_nonce  <= '0;
            core_ctr    <= '0;
            num_q       <= '0;
            issued      <= '0;
            drained     <= '0;
            outstanding <= 1'b0;
        end else begin
            if (core_start)
                outstanding <= 1'b1;
            if (core_fill) begin
                outstanding <= 1'b0;
                core_ctr    <= core_ctr + CTR_W'(1);
                issued      <= issued + NBLK_W'(1);
            end
            if (blk_drained)
                drained <= drained + NBLK_W'(1);

            case (state)
                IDLE: begin
                    if (start) begin
                        core_key    <= key;
                        core_nonce  <= nonce;
                        core_ctr    <= ctr_init;
                        num_q       <= num_blocks;
                        issued      <= '0;
                        drained     <= '0;
                        outstanding <= 1'b0;
                        state       <= CHECK;
                    end
                end
                CHECK: begin
                    if (num_q == '0)
                        state <= FIN;
                    else if (wrap)
                        state <= IDLE;
                    else
                        state <= RUN;
                end
                RUN: begin
                    if (blk_drained && last_blk)
                        state <= FIN;
                end
                FIN:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
